// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline.
//   XLEN       : datapath width
//   NOP_INSTR  : bubble instruction (addi x0,x0,0)
//   if_state_t : fetch-stage FSM states
package pipeline_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding on the bus (valid=1)
    WAIT  = 2'd1,  // request accepted, waiting for the response
    HOLD  = 2'd2   // response parked in the buffer while decode is stalled
  } if_state_t;

endpackage

// File: rtl/if_rsp_buffer.sv
// One-entry holding register for an instruction response that arrived while
// the pipeline was stalled.
//   clk, rst_n : clock, async active-low reset
//   i_load     : capture i_data/i_pc and mark valid
//   i_clear    : drop the entry (wins over i_load)
//   i_data     : instruction word to capture
//   i_pc       : PC of that instruction
//   o_data     : held instruction
//   o_pc       : held PC
//   o_valid    : entry is occupied
module if_rsp_buffer
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_data,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_data,
  output logic [XLEN-1:0] o_pc,
  output logic            o_valid
);

  logic [XLEN-1:0] r_data;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a single-outstanding
// request/response bus and drives the IF/ID register consumed by decode.
//   clk, rst_n       : clock, async active-low reset
//   stall            : hold PC and IF/ID
//   flush_if         : branch taken in decode; squash IF/ID, redirect PC
//   branch_target    : redirect PC (low two bits ignored)
//   imem_req_*       : fetch request (valid/ready/addr)
//   imem_rsp_*       : in-order response, one per accepted request
//   instr_ifid, pc_ifid, valid_ifid : IF/ID register
//   o_dbg_state      : current FSM state (if_state_t encoding)
//
// Handshake: a request transfers on a cycle where imem_req_valid and
// imem_req_ready are both high; the address holds steady while valid waits
// for ready, except when a flush redirects it. imem_rsp_valid has no ready:
// the stage always takes the response in the cycle it is presented.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush_if,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr_ifid,
  output logic [31:0] pc_ifid,
  output logic        valid_ifid,
  output logic [1:0]  o_dbg_state
);
  import pipeline_pkg::*;

  if_state_t   r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_req_pc, w_req_pc_nxt;
  logic        r_drop, w_drop_nxt;
  logic        r_run;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pc_ifid, w_pc_ifid_nxt;
  logic        r_valid_ifid, w_valid_ifid_nxt;

  logic        w_accept;
  logic [31:0] w_target;
  logic        w_buf_load, w_buf_clear;
  logic [31:0] w_buf_data, w_buf_pc;
  logic        w_buf_valid;

  // r_run keeps the request low while reset is held and for the cycle it
  // is released, so the first request appears one clock after release.
  assign imem_req_valid = r_run && (r_state == FETCH);
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_target       = branch_target & 32'hFFFF_FFFC;

  assign instr_ifid  = r_instr;
  assign pc_ifid     = r_pc_ifid;
  assign valid_ifid  = r_valid_ifid;
  assign o_dbg_state = r_state;

  if_rsp_buffer u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_data  (imem_rsp_data),
    .i_pc    (r_req_pc),
    .o_data  (w_buf_data),
    .o_pc    (w_buf_pc),
    .o_valid (w_buf_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_req_pc_nxt     = r_req_pc;
    w_drop_nxt       = r_drop;
    w_instr_nxt      = r_instr;
    w_pc_ifid_nxt    = r_pc_ifid;
    w_valid_ifid_nxt = r_valid_ifid;
    w_buf_load       = 1'b0;
    w_buf_clear      = 1'b0;

    if (flush_if) begin
      w_instr_nxt      = NOP_INSTR;
      w_valid_ifid_nxt = 1'b0;
      w_pc_nxt         = w_target;
      w_buf_clear      = 1'b1;
      // A response still owed for the old PC must be swallowed before the
      // target can be fetched. A request accepted this very cycle is owed
      // too, so it is handled exactly like WAIT.
      if ((r_state == WAIT && !imem_rsp_valid) || (r_state == FETCH && w_accept)) begin
        w_state_nxt = WAIT;
        w_drop_nxt  = 1'b1;
      end else begin
        w_state_nxt = FETCH;
        w_drop_nxt  = 1'b0;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (!stall) begin
            w_instr_nxt      = NOP_INSTR;
            w_valid_ifid_nxt = 1'b0;
          end
          if (w_accept) begin
            w_state_nxt  = WAIT;
            w_req_pc_nxt = r_pc;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (r_drop) begin
              w_drop_nxt  = 1'b0;
              w_state_nxt = FETCH;
              if (!stall) begin
                w_instr_nxt      = NOP_INSTR;
                w_valid_ifid_nxt = 1'b0;
              end
            end else if (!stall) begin
              w_instr_nxt      = imem_rsp_data;
              w_pc_ifid_nxt    = r_req_pc;
              w_valid_ifid_nxt = 1'b1;
              w_pc_nxt         = r_pc + 32'd4;
              w_state_nxt      = FETCH;
            end else begin
              w_buf_load  = 1'b1;
              w_state_nxt = HOLD;
            end
          end else if (!stall) begin
            w_instr_nxt      = NOP_INSTR;
            w_valid_ifid_nxt = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            w_instr_nxt      = w_buf_data;
            w_pc_ifid_nxt    = w_buf_pc;
            w_valid_ifid_nxt = w_buf_valid;
            w_pc_nxt         = r_pc + 32'd4;
            w_buf_clear      = 1'b1;
            w_state_nxt      = FETCH;
          end
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC & 32'hFFFF_FFFC;
      r_req_pc     <= '0;
      r_drop       <= 1'b0;
      r_run        <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_pc_ifid    <= '0;
      r_valid_ifid <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_req_pc     <= w_req_pc_nxt;
      r_drop       <= w_drop_nxt;
      r_run        <= 1'b1;
      r_instr      <= w_instr_nxt;
      r_pc_ifid    <= w_pc_ifid_nxt;
      r_valid_ifid <= w_valid_ifid_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] S_FETCH = 32'd0;
  localparam logic [31:0] S_WAIT  = 32'd1;
  localparam logic [31:0] S_HOLD  = 32'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        stall, flush_if;
  logic [31:0] branch_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr_ifid, pc_ifid;
  logic        valid_ifid;
  logic [1:0]  o_dbg_state;

  int total = 0;
  int bad   = 0;

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush_if       (flush_if),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_ifid     (instr_ifid),
    .pc_ifid        (pc_ifid),
    .valid_ifid     (valid_ifid),
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc, input logic v);
    chk({tag, ".instr"}, instr_ifid, ins);
    chk({tag, ".pc"}, pc_ifid, pc);
    chk({tag, ".valid"}, {31'd0, valid_ifid}, {31'd0, v});
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [31:0] addr);
    chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, v});
    if (v) chk({tag, ".req_addr"}, imem_req_addr, addr);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; stall = 1'b0; flush_if = 1'b0; branch_target = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    tick(); tick();
    chk_ifid("reset", NOP, 32'h0, 1'b0);
    chk_req("reset", 1'b0, 32'h0);
    chk("reset.state", {30'd0, o_dbg_state}, S_FETCH);

    // 1: first fetch from 0 with zero-wait memory
    rst_n = 1'b1;
    tick();
    chk_req("t1.first", 1'b1, 32'h0);
    imem_req_ready = 1'b1;
    tick();
    chk("t1.wait", {30'd0, o_dbg_state}, S_WAIT);
    chk_req("t1.wait", 1'b0, 32'h0);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
    tick();
    imem_rsp_valid = 1'b0;
    chk_ifid("t1.ifid", 32'h0050_0093, 32'h0, 1'b1);
    chk_req("t1.next", 1'b1, 32'h4);

    // 2: fetch at 4, then stall while the fetch of 8 is in WAIT
    imem_req_ready = 1'b1;
    tick();
    chk_ifid("t2.bubble", NOP, 32'h0, 1'b0);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0113;
    tick();
    imem_rsp_valid = 1'b0;
    chk_ifid("t2.pc4", 32'h0010_0113, 32'h4, 1'b1);
    chk_req("t2.req8", 1'b1, 32'h8);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    stall = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_8133;
    tick();
    imem_rsp_valid = 1'b0;
    chk("t2.hold", {30'd0, o_dbg_state}, S_HOLD);
    chk_ifid("t2.stall1", NOP, 32'h4, 1'b0);
    chk_req("t2.stall1", 1'b0, 32'h0);
    tick();
    chk_req("t2.stall2", 1'b0, 32'h0);
    tick();
    chk_ifid("t2.stall3", NOP, 32'h4, 1'b0);
    chk_req("t2.stall3", 1'b0, 32'h0);
    stall = 1'b0;
    tick();
    chk_ifid("t2.release", 32'h0020_8133, 32'h8, 1'b1);
    chk_req("t2.next", 1'b1, 32'hC);

    // 3: flush in FETCH with ready=0, target 0x40
    flush_if = 1'b1; branch_target = 32'h40;
    tick();
    flush_if = 1'b0;
    chk("t3.instr", instr_ifid, NOP);
    chk("t3.valid", {31'd0, valid_ifid}, 32'd0);
    chk_req("t3.redirect", 1'b1, 32'h40);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0513;
    tick();
    imem_rsp_valid = 1'b0;
    chk_ifid("t3.ifid", 32'h0000_0513, 32'h40, 1'b1);
    chk_req("t3.next", 1'b1, 32'h44);

    // 4: flush in WAIT, memory answers 3 cycles after acceptance
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    flush_if = 1'b1; branch_target = 32'h100;
    tick();
    flush_if = 1'b0;
    chk("t4.wait", {30'd0, o_dbg_state}, S_WAIT);
    chk_req("t4.noreq", 1'b0, 32'h0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    chk_ifid("t4.dropped", NOP, 32'h40, 1'b0);
    chk_req("t4.target", 1'b1, 32'h100);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00C5_8593;
    tick();
    imem_rsp_valid = 1'b0;
    chk_ifid("t4.ifid", 32'h00C5_8593, 32'h100, 1'b1);

    // 5: flush and stall together while a response is parked in HOLD
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    stall = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A0_0293;
    tick();
    imem_rsp_valid = 1'b0;
    chk("t5.hold", {30'd0, o_dbg_state}, S_HOLD);
    flush_if = 1'b1; branch_target = 32'h203;
    tick();
    flush_if = 1'b0;
    chk("t5.instr", instr_ifid, NOP);
    chk("t5.valid", {31'd0, valid_ifid}, 32'd0);
    chk("t5.state", {30'd0, o_dbg_state}, S_FETCH);
    chk_req("t5.aligned", 1'b1, 32'h200);
    stall = 1'b0;
    tick();
    chk("t5.noleak.instr", instr_ifid, NOP);
    chk("t5.noleak.valid", {31'd0, valid_ifid}, 32'd0);

    // 6a: PC wrap from 0xFFFFFFFC
    flush_if = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    flush_if = 1'b0;
    chk_req("t6.top", 1'b1, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0073;
    tick();
    imem_rsp_valid = 1'b0;
    chk_ifid("t6.ifid", 32'h0010_0073, 32'hFFFF_FFFC, 1'b1);
    chk_req("t6.wrap", 1'b1, 32'h0);

    // 6b: asynchronous reset while in WAIT
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("t6.inwait", {30'd0, o_dbg_state}, S_WAIT);
    #2;
    rst_n = 1'b0;
    #1;
    chk_ifid("t6.rst", NOP, 32'h0, 1'b0);
    chk_req("t6.rst", 1'b0, 32'h0);
    chk("t6.rst.state", {30'd0, o_dbg_state}, S_FETCH);
    tick();
    rst_n = 1'b1;
    tick();
    chk_req("t6.restart", 1'b1, 32'h0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so a stuck run still ends.
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the decode stage.
- Owns the program counter and talks to instruction memory over a single-outstanding request/response handshake.
- Drives the IF/ID pipeline register (PC, instruction, valid) consumed by decode.
- Honours the hazard unit's stall and decode's branch flush/redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value fetched first after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on flush or empty.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- stall  in  1  hazard unit: hold PC and IF/ID contents
- flush_if  in  1  decode: branch taken; squash IF/ID and redirect
- branch_target  in  32  redirect PC, valid when flush_if=1
- imem_req_valid  out  1  fetch request
- imem_req_addr  out  32  fetch address (word aligned)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  instruction returned (one per accepted request, in order)
- imem_rsp_data  in  32  returned instruction
- instr_ifid  out  32  IF/ID instruction
- pc_ifid  out  32  IF/ID PC
- valid_ifid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset, asynchronous: pc_q=RESET_PC, state=FETCH, drop_q=0, buf_valid=0, instr_ifid=NOP_INSTR, pc_ifid=0, valid_ifid=0, imem_req_valid=0 for the reset cycle.
- FSM states:
  - FETCH: imem_req_valid=1, addr=pc_q. On req_ready, go to WAIT and latch req_pc=pc_q.
  - WAIT: on rsp_valid, either write IF/ID directly (not stalled) or capture the response into a 1-entry buffer and go to HOLD (stalled). On direct write, pc_q+=4 and return to FETCH.
  - HOLD: when stall deasserts, move the buffer into IF/ID, set pc_q+=4, and return to FETCH. No new request is issued while in HOLD.
- Best-case throughput is one instruction per 2 cycles (request, then response). Zero-wait memory: response may arrive the cycle after acceptance.
- IF/ID update when not stalled and a response is available: instr_ifid=rsp_data, pc_ifid=req_pc, valid_ifid=1.
- IF/ID update when not stalled and no response is available: write a bubble (NOP_INSTR, valid=0, pc_ifid unchanged).
- stall=1: IF/ID and pc_q hold their values. The outstanding request is still accepted or returned; the response goes to the buffer.
- flush_if=1 has priority over stall and over everything else:
  - IF/ID <= NOP_INSTR, valid=0.
  - pc_q <= branch_target.
  - buf_valid <= 0.
  - State handling: in WAIT with rsp_valid not present this cycle, set drop_q=1 and stay in WAIT. Otherwise go to FETCH.
- drop_q=1: the next rsp_valid is discarded (IF/ID not written), drop_q clears, and the state goes to FETCH, which fetches branch_target.
- flush_if in FETCH while imem_req_ready=1: the request is considered issued for the old PC, so treat it as WAIT with drop_q=1.
- branch_target[1:0] is ignored; the address is forced word aligned.
- The pc_q+4 increment wraps modulo 2^32.
- imem_req_addr must be stable while imem_req_valid=1 and ready=0, unless flush_if fires, in which case it changes to the target.
- Asserting rst_n low mid-transaction abandons any outstanding response. After reset, the memory is assumed idle (bench resets memory too).

Decomposition:
- Shared package pipeline_pkg:
  - NOP_INSTR constant.
  - if_state_t enum {FETCH, WAIT, HOLD}.
  - XLEN=32.
- One sub-module, if_rsp_buffer: a 1-entry holding register (data, pc, valid) with load/clear, used for the HOLD path.

Test Plan:
1. Reset release with zero-wait memory returning the word 0x00500093 at 0 → imem_req_addr=0 the first cycle after reset. Then instr_ifid=0x00500093, pc_ifid=0, valid_ifid=1. The next request address is 4.
2. Stall asserted while in WAIT, memory returns 0x00208133 at PC 8, stall held for 3 cycles → IF/ID unchanged during the stall, no new request issued. One cycle after stall drops, instr_ifid=0x00208133 and pc_ifid=8.
3. flush_if=1 with branch_target=0x40 in FETCH, ready=0 → IF/ID becomes NOP with valid=0. The next request address is 0x40, and the instruction at 0x40 appears with pc_ifid=0x40.
4. flush_if=1 in WAIT with a 3-cycle memory latency, target 0x100 → the late response for the old PC is dropped (IF/ID stays NOP). The following request uses address 0x100.
5. flush_if and stall asserted together → flush wins: IF/ID becomes NOP, pc redirected, buffer cleared.
6. pc=0xFFFFFFFC fetched → the next request address is 0x00000000. Separately, reset asserted during WAIT → all outputs return to their reset values immediately.
